memory_wcomb_master_256bit: RTL and testbench
=============================================

Name: memory_wcomb_master_256bit

Overview:
- Initiator for the 16-entry x 256-bit byte-enabled line memory used in simulation.
- Accepts 32-bit word reads/writes from a core-side requester and merges writes into a single-line write-combining buffer.
- Drives the memory's write port: write enable, 4-bit line address, 256-bit data and 32-bit byte enable.
- Issues line reads and returns the selected 32-bit word.

Parameters:
- FLUSH_TIMEOUT, 16: idle cycles before an automatic buffer flush; only used with the optional feature; legal range 1..255.

Ports:
- iCLOCK  in  1  clock; all logic on posedge
- iRESET  in  1  asynchronous, active-high reset
- iREQ_VALID  in  1  request present
- oREQ_BUSY  out  1  registered; request accepted when iREQ_VALID && !oREQ_BUSY
- iREQ_RW  in  1  1 = write, 0 = read
- iREQ_ADDR  in  7  word address; [6:3] = line, [2:0] = word within line
- iREQ_MASK  in  4  byte mask for writes; bit b selects bits [8b+7:8b] of the word
- iREQ_DATA  in  32  write data
- iFLUSH  in  1  level request to write back the buffer
- oEMPTY  out  1  buffer holds no pending bytes
- oRD_VALID  out  1  one-cycle pulse; oRD_DATA valid
- oRD_DATA  out  32  read word
- oMEM_WR_ENA  out  1  memory write strobe
- oMEM_WR_ADDR  out  4  memory write line
- oMEM_WR_DATA  out  256  memory write data
- oMEM_BYTE_ENA  out  32  memory byte enable
- oMEM_RD_ADDR  out  4  memory read line
- iMEM_RD_DATA  in  256  memory read data; combinational from oMEM_RD_ADDR

Behaviour:
- Reset (asynchronous, active-high):
  - State = S_IDLE.
  - Buffer is invalid, its mask = 0, oEMPTY = 1.
  - All other outputs = 0.
  - Reset during S_FLUSH aborts the write; buffered bytes are lost.
- Buffer contents: valid bit, 4-bit line tag, 256-bit data, 32-bit byte mask.
- Byte mapping: word w, mask bit b maps to buffer byte 4w+b, i.e. bits [32w+8b+7 : 32w+8b].
- Memory outputs are driven combinationally from state and buffer registers.
- oMEM_WR_ENA is high only in S_FLUSH; in all other states oMEM_BYTE_ENA = 0.
- oREQ_BUSY = (state != S_IDLE) || flush-pending.
- Requests accepted in S_IDLE are captured into pending registers (rw, line, word, mask, data).
- Write hit (buffer invalid, or tag == line):
  - Merge masked bytes at the acceptance edge; set mask bits; set valid and tag.
  - Stay in S_IDLE; next request can be accepted the following cycle.
  - Mask 4'b0000: accepted, no change; does not allocate an invalid buffer.
- Write miss (valid, tag != line, mask != 0): go to S_FLUSH with the request pending.
- S_FLUSH (exactly 1 cycle):
  - oMEM_WR_ENA = 1, oMEM_WR_ADDR = tag, oMEM_WR_DATA = buffer, oMEM_BYTE_ENA = buffer mask.
  - Next edge: buffer invalid, mask = 0.
  - Then: pending write -> S_ALLOC; pending read -> S_READ; flush-only -> S_IDLE.
- S_ALLOC (1 cycle): load pending write as a fresh line (mask = only its 4 bits), then -> S_IDLE.
- Read:
  - If buffer is valid and tag == line, go to S_FLUSH first; otherwise go straight to S_READ.
  - S_READ: oMEM_RD_ADDR = pending line; capture word [32w+31:32w] into oRD_DATA; oRD_VALID = 1 next cycle; -> S_IDLE.
  - Latency from acceptance edge t: oRD_VALID at t+2 with no flush, t+3 with flush.
  - oRD_DATA holds its value after the pulse.
- iFLUSH:
  - Sampled only in S_IDLE when iREQ_VALID is low.
  - Buffer valid -> S_FLUSH; buffer empty -> ignored.
  - iREQ_VALID has priority over iFLUSH in the same cycle.
- A buffer with a full mask (32'hFFFFFFFF) stays resident until a miss, a same-line read, or a flush.

Optional Feature:
- MEMORY_WCOMB_TIMEOUT_EN defined:
  - 8-bit idle counter clears on reset, on any accepted request, and whenever the buffer is empty.
  - Increments in S_IDLE while the buffer is valid and no request is accepted.
  - At FLUSH_TIMEOUT: go to S_FLUSH, counter clears.
  - A request arriving in the same cycle wins; the counter clears.
- Undefined: no counter; the buffer flushes only on a miss, a same-line read, or iFLUSH.

Test Plan:
- Write 0x11223344 mask 4'hF to addr 7'h00, then write 0xAABBCCDD mask 4'h3 to 7'h01, then iFLUSH -> one WR_ENA cycle: WR_ADDR = 0, BYTE_ENA = 32'h0000003F, WR_DATA[47:0] = 48'hCCDD_11223344; then oEMPTY = 1.
- Write to line 2 word 0 (0xDEADBEEF, mask F), then write to line 5 word 7 (0x01020304, mask F) -> flush of line 2 (BYTE_ENA = 32'h0000000F); buffer tag = 5, mask = 32'hF0000000; oREQ_BUSY high for 2 cycles.
- Read 7'h13 with an empty buffer, memory line 2 word 3 = 0xCAFEF00D -> oMEM_RD_ADDR = 2 in S_READ; oRD_VALID at t+2 with oRD_DATA = 0xCAFEF00D.
- Write 0x55 mask 4'h1 to 7'h13, then read 7'h13 -> flush (BYTE_ENA = 32'h00001000) precedes the read; oRD_VALID at t+3 reflects the merged byte.
- Assert iRESET during S_FLUSH -> oMEM_WR_ENA drops immediately; no write lands; all outputs 0; oEMPTY = 1.
- MEMORY_WCOMB_TIMEOUT_EN with FLUSH_TIMEOUT = 4: single write, then idle -> flush occurs exactly 4 idle cycles after acceptance; without the macro, no flush after 100 cycles.

Source files
------------

// File: rtl/memory_wcomb_master_256bit.sv
// ============================================================================
// memory_wcomb_master_256bit
//
// Initiator for a 16-entry x 256-bit byte-enabled line memory.  Core-side
// 32-bit word writes are merged into a single-line write-combining buffer.
// The buffer is written back to memory when a write to a different line
// arrives, when a read targets the buffered line, or on iFLUSH.  Reads fetch
// a line from memory and return the addressed 32-bit word.
//
// Optional feature (compile-time macro MEMORY_WCOMB_TIMEOUT_EN):
//   An 8-bit idle counter flushes a valid buffer after FLUSH_TIMEOUT idle
//   cycles.  With the macro undefined there is no counter.
//
// Parameters:
//   FLUSH_TIMEOUT   idle cycles before an automatic flush (1..255); only
//                   meaningful with MEMORY_WCOMB_TIMEOUT_EN
//
// Ports:
//   iCLOCK          clock, all logic on posedge
//   iRESET          asynchronous, active-high reset
//   iREQ_VALID      request present
//   oREQ_BUSY       registered; request accepted when iREQ_VALID && !oREQ_BUSY
//   iREQ_RW         1 = write, 0 = read
//   iREQ_ADDR[6:0]  word address: [6:3] line, [2:0] word within line
//   iREQ_MASK[3:0]  write byte mask, bit b selects word bits [8b+7:8b]
//   iREQ_DATA[31:0] write data
//   iFLUSH          level request to write back the buffer
//   oEMPTY          buffer holds no pending bytes
//   oRD_VALID       one-cycle pulse, oRD_DATA valid
//   oRD_DATA[31:0]  read word (held after the pulse)
//   oMEM_WR_ENA     memory write strobe
//   oMEM_WR_ADDR    memory write line
//   oMEM_WR_DATA    memory write data (256 bits)
//   oMEM_BYTE_ENA   memory byte enables (32 bits)
//   oMEM_RD_ADDR    memory read line
//   iMEM_RD_DATA    memory read data, combinational from oMEM_RD_ADDR
//
// State   | Meaning
// --------+----------------------------------------------------------------
// S_IDLE  | accept requests, merge write hits, watch iFLUSH / idle timer
// S_FLUSH | one-cycle write-back of the buffer, buffer invalidated after
// S_ALLOC | load the pending (missed) write as a fresh buffer line
// S_READ  | present pending line to memory, capture the addressed word
// ============================================================================
module memory_wcomb_master_256bit #(
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic         iCLOCK,
    input  logic         iRESET,
    input  logic         iREQ_VALID,
    output logic         oREQ_BUSY,
    input  logic         iREQ_RW,
    input  logic [6:0]   iREQ_ADDR,
    input  logic [3:0]   iREQ_MASK,
    input  logic [31:0]  iREQ_DATA,
    input  logic         iFLUSH,
    output logic         oEMPTY,
    output logic         oRD_VALID,
    output logic [31:0]  oRD_DATA,
    output logic         oMEM_WR_ENA,
    output logic [3:0]   oMEM_WR_ADDR,
    output logic [255:0] oMEM_WR_DATA,
    output logic [31:0]  oMEM_BYTE_ENA,
    output logic [3:0]   oMEM_RD_ADDR,
    input  logic [255:0] iMEM_RD_DATA
);

    if (FLUSH_TIMEOUT < 1 || FLUSH_TIMEOUT > 255) begin : gBadTimeout
        $error("FLUSH_TIMEOUT must lie in 1..255");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLUSH = 2'd1,
        S_ALLOC = 2'd2,
        S_READ  = 2'd3
    } stateT;

    stateT          state;

    logic           bufValid;
    logic [3:0]     bufTag;
    logic [255:0]   bufData;
    logic [31:0]    bufMask;

    logic           pendRw;
    logic           pendFlushOnly;
    logic [3:0]     pendLine;
    logic [2:0]     pendWord;
    logic [3:0]     pendMask;
    logic [31:0]    pendData;

    logic           reqBusy;
    logic           rdValid;
    logic [31:0]    rdData;

    logic           accept;
    logic           reqLineHit;
    logic           timeoutHit;

    logic [255:0]   hitData;
    logic [31:0]    hitMask;
    logic [255:0]   allocData;
    logic [31:0]    allocMask;

    assign accept     = (state == S_IDLE) && iREQ_VALID && !reqBusy;
    assign reqLineHit = bufValid && (bufTag == iREQ_ADDR[6:3]);

    // Merged images: the incoming request over the current buffer (hit path)
    // and the pending request over a blank line (allocate path).  An invalid
    // buffer contributes nothing, so stale data never reaches memory.
    always_comb begin
        hitData   = bufValid ? bufData : '0;
        hitMask   = bufValid ? bufMask : '0;
        allocData = '0;
        allocMask = '0;
        for (int b = 0; b < 4; b++) begin
            if (iREQ_MASK[b]) begin
                hitData[8*(4*int'(iREQ_ADDR[2:0]) + b) +: 8] = iREQ_DATA[8*b +: 8];
                hitMask[4*int'(iREQ_ADDR[2:0]) + b]          = 1'b1;
            end
            if (pendMask[b]) begin
                allocData[8*(4*int'(pendWord) + b) +: 8] = pendData[8*b +: 8];
                allocMask[4*int'(pendWord) + b]          = 1'b1;
            end
        end
    end

`ifdef MEMORY_WCOMB_TIMEOUT_EN
    logic [7:0] idleCnt;

    // Fires on the idle edge that would bring the counter to FLUSH_TIMEOUT.
    assign timeoutHit = (state == S_IDLE) && bufValid && !accept &&
                        (idleCnt + 8'd1 == 8'(FLUSH_TIMEOUT));

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            idleCnt <= '0;
        end else if ((state != S_IDLE) || accept || !bufValid || iFLUSH || timeoutHit) begin
            idleCnt <= '0;
        end else begin
            idleCnt <= idleCnt + 8'd1;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state         <= S_IDLE;
            bufValid      <= 1'b0;
            bufTag        <= '0;
            bufData       <= '0;
            bufMask       <= '0;
            pendRw        <= 1'b0;
            pendFlushOnly <= 1'b0;
            pendLine      <= '0;
            pendWord      <= '0;
            pendMask      <= '0;
            pendData      <= '0;
            reqBusy       <= 1'b0;
            rdValid       <= 1'b0;
            rdData        <= '0;
        end else begin
            rdValid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        pendRw        <= iREQ_RW;
                        pendFlushOnly <= 1'b0;
                        pendLine      <= iREQ_ADDR[6:3];
                        pendWord      <= iREQ_ADDR[2:0];
                        pendMask      <= iREQ_MASK;
                        pendData      <= iREQ_DATA;
                        if (iREQ_RW) begin
                            if (iREQ_MASK == 4'b0000) begin
                                // empty write: accepted, nothing to merge
                            end else if (!bufValid || reqLineHit) begin
                                bufData  <= hitData;
                                bufMask  <= hitMask;
                                bufValid <= 1'b1;
                                bufTag   <= iREQ_ADDR[6:3];
                            end else begin
                                state   <= S_FLUSH;
                                reqBusy <= 1'b1;
                            end
                        end else if (reqLineHit) begin
                            // write back first so the read sees merged bytes
                            state   <= S_FLUSH;
                            reqBusy <= 1'b1;
                        end else begin
                            state   <= S_READ;
                            reqBusy <= 1'b1;
                        end
                    end else if (bufValid && (iFLUSH || timeoutHit)) begin
                        pendFlushOnly <= 1'b1;
                        state         <= S_FLUSH;
                        reqBusy       <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    bufValid <= 1'b0;
                    bufMask  <= '0;
                    if (pendFlushOnly) begin
                        pendFlushOnly <= 1'b0;
                        state         <= S_IDLE;
                        reqBusy       <= 1'b0;
                    end else if (pendRw) begin
                        state <= S_ALLOC;
                    end else begin
                        state <= S_READ;
                    end
                end

                S_ALLOC: begin
                    bufValid <= 1'b1;
                    bufTag   <= pendLine;
                    bufData  <= allocData;
                    bufMask  <= allocMask;
                    state    <= S_IDLE;
                    reqBusy  <= 1'b0;
                end

                S_READ: begin
                    rdData  <= iMEM_RD_DATA[{pendWord, 5'b00000} +: 32];
                    rdValid <= 1'b1;
                    state   <= S_IDLE;
                    reqBusy <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    reqBusy <= 1'b0;
                end
            endcase
        end
    end

    // Memory ports decode directly from state so a reset mid-flush drops the
    // strobe without waiting for a clock edge.
    always_comb begin
        oMEM_WR_ENA   = 1'b0;
        oMEM_WR_ADDR  = '0;
        oMEM_WR_DATA  = '0;
        oMEM_BYTE_ENA = '0;
        oMEM_RD_ADDR  = '0;
        if (state == S_FLUSH) begin
            oMEM_WR_ENA   = 1'b1;
            oMEM_WR_ADDR  = bufTag;
            oMEM_WR_DATA  = bufData;
            oMEM_BYTE_ENA = bufMask;
        end
        if (state == S_READ) begin
            oMEM_RD_ADDR = pendLine;
        end
    end

    assign oREQ_BUSY = reqBusy;
    assign oEMPTY    = !bufValid;
    assign oRD_VALID = rdValid;
    assign oRD_DATA  = rdData;

endmodule

// File: tb/tb_memory_wcomb_master_256bit.sv
module tb_memory_wcomb_master_256bit;

    logic         iCLOCK = 1'b0;
    logic         iRESET;
    logic         iREQ_VALID;
    logic         oREQ_BUSY;
    logic         iREQ_RW;
    logic [6:0]   iREQ_ADDR;
    logic [3:0]   iREQ_MASK;
    logic [31:0]  iREQ_DATA;
    logic         iFLUSH;
    logic         oEMPTY;
    logic         oRD_VALID;
    logic [31:0]  oRD_DATA;
    logic         oMEM_WR_ENA;
    logic [3:0]   oMEM_WR_ADDR;
    logic [255:0] oMEM_WR_DATA;
    logic [31:0]  oMEM_BYTE_ENA;
    logic [3:0]   oMEM_RD_ADDR;
    logic [255:0] iMEM_RD_DATA;

    int passed = 0;
    int total  = 0;

    // line memory model with a bench-side preload port
    logic [255:0] mem [16];
    logic         preEna  = 1'b0;
    logic [3:0]   preAddr = '0;
    logic [255:0] preData = '0;
    int           wrCount = 0;

    always #5 iCLOCK = ~iCLOCK;

    assign iMEM_RD_DATA = mem[oMEM_RD_ADDR];

    always @(posedge iCLOCK) begin
        if (preEna) begin
            mem[preAddr] <= preData;
        end
        if (oMEM_WR_ENA) begin
            wrCount <= wrCount + 1;
            for (int i = 0; i < 32; i++) begin
                if (oMEM_BYTE_ENA[i]) begin
                    mem[oMEM_WR_ADDR][8*i +: 8] <= oMEM_WR_DATA[8*i +: 8];
                end
            end
        end
    end

    memory_wcomb_master_256bit #(.FLUSH_TIMEOUT(4)) dut (
        .iCLOCK        (iCLOCK),
        .iRESET        (iRESET),
        .iREQ_VALID    (iREQ_VALID),
        .oREQ_BUSY     (oREQ_BUSY),
        .iREQ_RW       (iREQ_RW),
        .iREQ_ADDR     (iREQ_ADDR),
        .iREQ_MASK     (iREQ_MASK),
        .iREQ_DATA     (iREQ_DATA),
        .iFLUSH        (iFLUSH),
        .oEMPTY        (oEMPTY),
        .oRD_VALID     (oRD_VALID),
        .oRD_DATA      (oRD_DATA),
        .oMEM_WR_ENA   (oMEM_WR_ENA),
        .oMEM_WR_ADDR  (oMEM_WR_ADDR),
        .oMEM_WR_DATA  (oMEM_WR_DATA),
        .oMEM_BYTE_ENA (oMEM_BYTE_ENA),
        .oMEM_RD_ADDR  (oMEM_RD_ADDR),
        .iMEM_RD_DATA  (iMEM_RD_DATA)
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    // drive one request for a single edge; returns 1 time unit after it
    task automatic request(input logic rw, input logic [6:0] addr,
                           input logic [3:0] mask, input logic [31:0] data);
        iREQ_VALID = 1'b1;
        iREQ_RW    = rw;
        iREQ_ADDR  = addr;
        iREQ_MASK  = mask;
        iREQ_DATA  = data;
        tick();
        iREQ_VALID = 1'b0;
    endtask

    task automatic flushPulse();
        iFLUSH = 1'b1;
        tick();
        iFLUSH = 1'b0;
    endtask

    task automatic preload(input logic [3:0] addr, input logic [255:0] data);
        preEna  = 1'b1;
        preAddr = addr;
        preData = data;
        tick();
        preEna  = 1'b0;
    endtask

    int snap;
    int seen;

    initial begin
        iRESET     = 1'b1;
        iREQ_VALID = 1'b0;
        iREQ_RW    = 1'b0;
        iREQ_ADDR  = '0;
        iREQ_MASK  = '0;
        iREQ_DATA  = '0;
        iFLUSH     = 1'b0;
        tick();
        tick();

        check("rst_busy",    oREQ_BUSY,     0);
        check("rst_empty",   oEMPTY,        1);
        check("rst_rdvalid", oRD_VALID,     0);
        check("rst_rddata",  oRD_DATA,      0);
        check("rst_wrena",   oMEM_WR_ENA,   0);
        check("rst_wrdata",  oMEM_WR_DATA,  0);
        check("rst_byteena", oMEM_BYTE_ENA, 0);
        check("rst_rdaddr",  oMEM_RD_ADDR,  0);
        iRESET = 1'b0;
        preload(4'd0, '0);
        preload(4'd6, '0);

        // mask-0 write on an empty buffer allocates nothing; iFLUSH is ignored
        request(1'b1, 7'h20, 4'h0, 32'h12345678);
        check("mask0_empty", oEMPTY,    1);
        check("mask0_busy",  oREQ_BUSY, 0);
        flushPulse();
        check("flush_empty_ignored", oMEM_WR_ENA, 0);

        // write combining within line 0, request beats iFLUSH in the same cycle
        request(1'b1, 7'h00, 4'hF, 32'h11223344);
        check("t1_empty", oEMPTY, 0);
        request(1'b1, 7'h01, 4'h3, 32'hAABBCCDD);
        check("t1_busy", oREQ_BUSY, 0);
        iFLUSH = 1'b1;
        request(1'b1, 7'h02, 4'h4, 32'h99887766);
        iFLUSH = 1'b0;
        check("prio_busy",  oREQ_BUSY,   0);
        check("prio_wrena", oMEM_WR_ENA, 0);
        flushPulse();
        check("t1_wrena",   oMEM_WR_ENA,        1);
        check("t1_wraddr",  oMEM_WR_ADDR,       0);
        check("t1_byteena", oMEM_BYTE_ENA,      32'h0000043F);
        check("t1_wrdata",  oMEM_WR_DATA[47:0], 48'hCCDD_11223344);
        check("t1_byte10",  oMEM_WR_DATA[87:80], 8'h88);
        check("t1_busyfl",  oREQ_BUSY,          1);
        tick();
        check("t1_wrena_off", oMEM_WR_ENA, 0);
        check("t1_empty_after", oEMPTY,    1);
        check("t1_mem", mem[0][47:0], 48'hCCDD_11223344);

        // miss: line 2 buffered, write to line 5 word 7 forces write-back
        request(1'b1, 7'h10, 4'hF, 32'hDEADBEEF);
        request(1'b1, 7'h2F, 4'hF, 32'h01020304);
        check("t2_wrena",   oMEM_WR_ENA,         1);
        check("t2_wraddr",  oMEM_WR_ADDR,        2);
        check("t2_byteena", oMEM_BYTE_ENA,       32'h0000000F);
        check("t2_wrdata",  oMEM_WR_DATA[31:0],  32'hDEADBEEF);
        check("t2_busy1",   oREQ_BUSY,           1);
        tick();
        check("t2_busy2",   oREQ_BUSY,   1);
        check("t2_alloc_wr", oMEM_WR_ENA, 0);
        tick();
        check("t2_busy3",   oREQ_BUSY, 0);
        check("t2_empty",   oEMPTY,    0);
        flushPulse();
        check("t2_fl_addr",    oMEM_WR_ADDR,           5);
        check("t2_fl_byteena", oMEM_BYTE_ENA,          32'hF0000000);
        check("t2_fl_data",    oMEM_WR_DATA[255:224],  32'h01020304);
        tick();

        // read with empty buffer: line 2 word 3
        preload(4'd2, 256'hCAFEF00D << 96);
        request(1'b0, 7'h13, 4'h0, 32'h0);
        check("t3_rdaddr",  oMEM_RD_ADDR, 2);
        check("t3_busy",    oREQ_BUSY,    1);
        check("t3_rv_t1",   oRD_VALID,    0);
        tick();
        check("t3_rv_t2",   oRD_VALID, 1);
        check("t3_rddata",  oRD_DATA,  32'hCAFEF00D);
        check("t3_busy_off", oREQ_BUSY, 0);
        tick();
        check("t3_pulse",   oRD_VALID, 0);
        check("t3_hold",    oRD_DATA,  32'hCAFEF00D);

        // same-line read after a byte write: flush precedes the read
        request(1'b1, 7'h13, 4'h1, 32'h00000055);
        request(1'b0, 7'h13, 4'h0, 32'h0);
        check("t4_wrena",   oMEM_WR_ENA,          1);
        check("t4_byteena", oMEM_BYTE_ENA,        32'h00001000);
        check("t4_byte",    oMEM_WR_DATA[103:96], 8'h55);
        check("t4_rv_t1",   oRD_VALID,            0);
        tick();
        check("t4_rdaddr",  oMEM_RD_ADDR, 2);
        check("t4_rv_t2",   oRD_VALID,    0);
        tick();
        check("t4_rv_t3",   oRD_VALID, 1);
        check("t4_rddata",  oRD_DATA,  32'hCAFEF055);
        check("t4_empty",   oEMPTY,    1);
        tick();

        // reset while flushing
        request(1'b1, 7'h30, 4'hF, 32'h12345678);
        flushPulse();
        check("t5_inflush", oMEM_WR_ENA, 1);
        snap = wrCount;
        #1 iRESET = 1'b1;
        #1;
        check("t5_wrena",   oMEM_WR_ENA,   0);
        check("t5_byteena", oMEM_BYTE_ENA, 0);
        check("t5_rddata",  oRD_DATA,      0);
        check("t5_busy",    oREQ_BUSY,     0);
        check("t5_empty",   oEMPTY,        1);
        tick();
        iRESET = 1'b0;
        tick();
        check("t5_nowrite", wrCount - snap, 0);
        check("t5_mem6",    mem[6],         0);

        // idle timeout behaviour
        request(1'b1, 7'h08, 4'hF, 32'hAABBCCDD);
`ifdef MEMORY_WCOMB_TIMEOUT_EN
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("t6_to_cycle%0d", i), oMEM_WR_ENA, (i == 4) ? 1'b1 : 1'b0);
        end
        check("t6_to_addr", oMEM_WR_ADDR, 1);
        tick();
        check("t6_to_empty", oEMPTY, 1);
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (oMEM_WR_ENA) seen++;
        end
        check("t6_no_timeout", seen, 0);
        check("t6_resident",   oEMPTY, 0);
        flushPulse();
        check("t6_flush_addr", oMEM_WR_ADDR, 1);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
